// File: rtl/mux_scan_n.sv
// N-channel pipelined selector with direct-select and auto-scan modes.
// Stage 1 captures the chosen lane; the output stage presents it one edge later.
module mux_scan_n #(
    parameter  int WIDTH  = 1,
    parameter  int CH_NUM = 16,
    parameter  int DWELL  = 4,
    localparam int SEL_W  = $clog2(CH_NUM)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [CH_NUM*WIDTH-1:0] din,
    input  logic [CH_NUM-1:0]       skip_mask,
    output logic [WIDTH-1:0]        dout,
    output logic [SEL_W-1:0]        dout_ch,
    output logic                    dout_valid,
    output logic                    scan_wrap
);

    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);

    logic              s1_valid_q;
    logic [WIDTH-1:0]  s1_data_q;
    logic [SEL_W-1:0]  s1_ch_q;
    logic [WIDTH-1:0]  dout_q;
    logic [SEL_W-1:0]  dout_ch_q;
    logic              dout_valid_q;
    logic              scan_wrap_q;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              mode_q;

    logic [SEL_W-1:0]  c_sel;
    logic [SEL_W-1:0]  low_idx;
    logic [SEL_W-1:0]  adv_from;
    logic [SEL_W-1:0]  nxt_ptr;
    logic              take;
    logic              adv;
    logic              wrap_d;
    logic              any_open;
    logic [WIDTH-1:0]  mux_out;

    // First unmasked index strictly after 'from', wrapping; returns 'from' if it is the only one.
    function automatic logic [SEL_W-1:0] next_after(input logic [SEL_W-1:0] from,
                                                    input logic [CH_NUM-1:0] m);
        logic [SEL_W-1:0] idx;
        next_after = from;
        for (int i = CH_NUM; i >= 1; i--) begin
            idx = from + SEL_W'(i);
            if (!m[idx]) next_after = idx;
        end
    endfunction

    always_comb begin
        low_idx = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (!skip_mask[i]) low_idx = SEL_W'(i);
        end
    end

    assign any_open = ~&skip_mask;

    always_comb begin
        c_sel    = sel;
        take     = 1'b0;
        adv      = 1'b0;
        adv_from = ptr_q;
        ptr_d    = ptr_q;
        dcnt_d   = dcnt_q;
        if (!mode) begin
            take = 1'b1;
        end else if (any_open) begin
            if (!mode_q) begin
                // Scan entry: this edge already counts as dwell cycle 0 on the lowest open lane.
                c_sel    = low_idx;
                take     = 1'b1;
                adv_from = low_idx;
                ptr_d    = low_idx;
                if (DWELL == 1) adv = 1'b1;
                else            dcnt_d = DCNT_W'(1);
            end else if (skip_mask[ptr_q]) begin
                adv = 1'b1;
            end else begin
                c_sel = ptr_q;
                take  = 1'b1;
                if (dcnt_q == DCNT_LAST) adv = 1'b1;
                else                     dcnt_d = dcnt_q + 1'b1;
            end
        end
        nxt_ptr = next_after(adv_from, skip_mask);
        wrap_d  = adv && (nxt_ptr <= adv_from);
        if (adv) begin
            ptr_d  = nxt_ptr;
            dcnt_d = '0;
        end
    end

    generate
        if (CH_NUM < 8) begin : g_flat
            assign mux_out = din[c_sel*WIDTH +: WIDTH];
        end else begin : g_tree
            localparam int NG = CH_NUM / 8;
            logic [WIDTH-1:0] grp [NG];
            for (genvar g = 0; g < NG; g++) begin : g_grp
                logic [8*WIDTH-1:0] lanes;
                assign lanes  = din[g*8*WIDTH +: 8*WIDTH];
                assign grp[g] = lanes[c_sel[2:0]*WIDTH +: WIDTH];
            end
            if (NG == 1) begin : g_one
                assign mux_out = grp[0];
            end else begin : g_comb
                assign mux_out = grp[c_sel[SEL_W-1:3]];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_ch_q      <= '0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            scan_wrap_q  <= 1'b0;
            ptr_q        <= '0;
            dcnt_q       <= '0;
            mode_q       <= 1'b0;
        end else if (en) begin
            s1_valid_q <= take;
            if (take) begin
                s1_data_q <= mux_out;
                s1_ch_q   <= c_sel;
            end
            if (s1_valid_q) begin
                dout_q    <= s1_data_q;
                dout_ch_q <= s1_ch_q;
            end
            dout_valid_q <= s1_valid_q;
            scan_wrap_q  <= wrap_d;
            ptr_q        <= ptr_d;
            dcnt_q       <= dcnt_d;
            mode_q       <= mode;
        end else begin
            dout_valid_q <= 1'b0;
            scan_wrap_q  <= 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;
    assign scan_wrap  = scan_wrap_q;

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised, pipelined N-channel, WIDTH-bit multiplexer; the next generation of the team's 16:1 selector.
- Two modes: direct select (external channel index) and auto-scan (an internal pointer steps through unmasked channels, DWELL cycles per channel).
- Registered output carries the channel tag and a valid flag.
- Sits between parallel sensor/data lanes and a single serial consumer.

Parameters:
WIDTH, 1, bits per channel (>=1)
CH_NUM, 16, channel count; power of two, 2..64
DWELL, 4, enabled cycles spent on each channel in scan mode (>=1)
SEL_W, log2(CH_NUM), derived localparam, not overridable

Ports:
clk  input  1  rising-edge clock, the block's only clock
rst_n  input  1  asynchronous active-low reset
en  input  1  sample enable; when low the pipeline stalls and no new sample is taken
mode  input  1  0 = direct select, 1 = auto-scan
sel  input  SEL_W  channel index in direct mode; ignored in scan mode
din  input  CH_NUM*WIDTH  channel c occupies din[c*WIDTH +: WIDTH]
skip_mask  input  CH_NUM  bit c = 1 excludes channel c from scan; ignored in direct mode
dout  output  WIDTH  selected sample
dout_ch  output  SEL_W  channel index that dout came from
dout_valid  output  1  dout/dout_ch hold a new sample this cycle
scan_wrap  output  1  one-cycle pulse when the scan pointer wraps

Behaviour:
- Reset (rst_n low, async): dout, dout_ch, dout_valid and scan_wrap = 0. Internal stage registers, pointer ptr and dwell counter dcnt = 0. mode_q = 0.
- Sampling edge k (en=1):
  - The chosen channel c_k is captured into stage 1, together with din slice c_k and a stage-1 valid bit.
  - Direct mode: c_k = sel.
  - Scan mode: c_k = ptr.
- Output stage: at the edge after a valid stage-1 capture, dout = captured data, dout_ch = c_k, dout_valid = 1.
  - Latency is 2 edges from sampling to dout_valid.
  - Throughput is 1 sample per cycle.
- en=0: stage 1 and the output register hold their values. dout_valid = 0 from the next edge. ptr and dcnt hold.
- Direct mode: every enabled edge samples; ptr and dcnt hold their values.
- Scan entry (mode=1, mode_q=0, en=1):
  - ptr is loaded with the lowest unmasked index; that edge samples that channel.
  - dcnt = 1, or stays 0 when DWELL = 1 and an advance occurs.
  - The same edge is treated as dwell cycle 0.
- Scan steady state, each enabled edge:
  - When dcnt == DWELL-1: dcnt <- 0 and ptr <- next unmasked index strictly after ptr, searching ascending and wrapping modulo CH_NUM. Otherwise dcnt <- dcnt+1.
- scan_wrap: registered, 1 for exactly the cycle after an advance whose new ptr <= old ptr, including the single-unmasked-channel case. It is 0 otherwise.
- Masked current channel (skip_mask[ptr] changed to 1 mid-dwell):
  - At the next enabled edge, no sample is taken (stage-1 valid = 0).
  - ptr advances to the next unmasked channel and dcnt <- 0.
- All channels masked in scan mode:
  - No sample is taken; dout_valid = 0.
  - ptr and dcnt hold; scan_wrap = 0.
- Mode 1->0 mid-dwell: the next enabled edge samples sel. ptr and dcnt freeze and are reinitialised on the next scan entry.
- Reset mid-operation: everything is cleared immediately. In-flight samples are discarded with no valid pulse.
- Width rules:
  - ptr, dout_ch: SEL_W bits.
  - dcnt: ceil(log2(DWELL)) bits, minimum 1.
  - Wrap comparison is unsigned.
- Implementation note: the selection tree is built from 8:1 group muxes plus a final combine, or a single level when CH_NUM < 8. This is not externally visible; only the 2-edge latency is contractual.

Test Plan:
- Reset/direct latency: CH_NUM=16, WIDTH=8, din[c] = 8'h10+c, mode=0, en=1; sel=5 at edge 1, sel=12 at edge 2 -> dout=8'h15/ch=5 valid after edge 2, dout=8'h1C/ch=12 after edge 3. Async rst_n low mid-stream -> outputs 0 immediately.
- Scan sequence: mode=1, DWELL=2, skip_mask=16'h0000 -> dout_ch sequence 0,0,1,1,...,15,15,0. scan_wrap pulses once, the cycle after the 15->0 advance.
- Mask skipping: skip_mask=16'hFFF5, i.e. only channels 1 and 3 unmasked; DWELL=1 -> dout_ch 1,3,1,3. scan_wrap is high after each 3->1 advance. Set mask bit 3 while ptr=3 -> one bubble (dout_valid=0), then the sequence continues 1,1,... with scan_wrap every advance.
- All masked: skip_mask=16'hFFFF, mode=1 -> dout_valid stays 0 and scan_wrap stays 0 for 20 cycles. Clear bit 7 -> ch 7 samples resume.
- Enable stall: scanning DWELL=4, drop en for 3 cycles mid-dwell -> dout_valid=0 during the stall. On resume, the remaining dwell count continues on the same channel with no skipped or repeated index.
- Mode toggle: scan at ptr=9, switch to mode=0 with sel=2 -> next valid dout_ch=2. Return to mode=1 -> scan restarts at the lowest unmasked channel with a full DWELL.
